hs_arith_stream_uminimize: RTL

HS_ARITH_STREAM_UMINIMIZE -- requirements
Module: hs_arith_stream_uminimize

---
 rtl/hs_arith_stream_uminimize.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/hs_arith_stream_uminimize.sv
// hs_arith_stream_uminimize
//   Streaming arg-min / arg-max over groups of beats. Each group is closed by
//   s_last or by reaching MAX_LEN beats; the winning value, its aux payload,
//   its 0-based position and the group length are then held on the result
//   port until the consumer takes them.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   s_valid/s_ready   : input beat handshake
//   s_data, s_aux     : unsigned compare value and payload carried with it
//   s_last            : final beat of a group
//   m_valid/m_ready   : result handshake
//   m_value, m_aux    : winning value and its payload
//   m_index, m_count  : winner position and number of beats in the group
//   m_overflow        : group closed at MAX_LEN without s_last

package hs_arith_stream_uminimize_pkg;
    typedef enum logic {BOOL_FALSE = 1'b0, BOOL_TRUE = 1'b1} bool_e;
endpackage

module hs_arith_stream_uminimize
    import hs_arith_stream_uminimize_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_LEN         = 16,
    parameter bool_e       FIND_MAX        = BOOL_FALSE,
    parameter bool_e       ENABLE_AUX_PATH = BOOL_TRUE,
    parameter type         AUX_DATA_TYPE   = logic,
    localparam int unsigned IDX_W = ($clog2(MAX_LEN) > 1) ? $clog2(MAX_LEN) : 1,
    localparam int unsigned CNT_W = $clog2(MAX_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  AUX_DATA_TYPE          s_aux,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_value,
    output AUX_DATA_TYPE          m_aux,
    output logic [IDX_W-1:0]      m_index,
    output logic [CNT_W-1:0]      m_count,
    output logic                  m_overflow
);

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] best_value_q, best_value_d;
    logic [IDX_W-1:0]      best_index_q, best_index_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      count_inc;
    logic                  overflow_q, overflow_d;
    logic                  accept;
    logic                  better;
    logic                  take;

    // Ready comes from state only; rst forces it low while reset is held.
    assign s_ready   = (state_q == ACCUM) && !rst;
    assign accept    = s_valid && s_ready;
    assign count_inc = count_q + CNT_W'(1);

    // Strict compare so ties keep the earlier (lower-index) beat.
    assign better = (FIND_MAX == BOOL_TRUE) ? (s_data > best_value_q)
                                            : (s_data < best_value_q);
    // First beat of a group loads unconditionally.
    assign take   = accept && ((count_q == '0) || better);

    always_comb begin
        state_d      = state_q;
        best_value_d = best_value_q;
        best_index_d = best_index_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    count_d = count_inc;
                    if (take) begin
                        best_value_d = s_data;
                        best_index_d = count_q[IDX_W-1:0];
                    end
                    if (s_last || (count_inc == CNT_W'(MAX_LEN))) begin
                        state_d    = HOLD;
                        overflow_d = !s_last;
                    end
                end
            end
            HOLD: begin
                if (m_ready) begin
                    state_d    = ACCUM;
                    count_d    = '0;
                    overflow_d = 1'b0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ACCUM;
            best_value_q <= '0;
            best_index_q <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            best_value_q <= best_value_d;
            best_index_q <= best_index_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
        end
    end

    assign m_valid    = (state_q == HOLD);
    assign m_value    = best_value_q;
    assign m_index    = best_index_q;
    assign m_count    = count_q;
    assign m_overflow = overflow_q;

    if (ENABLE_AUX_PATH == BOOL_TRUE) begin : g_aux
        AUX_DATA_TYPE best_aux_q, best_aux_d;

        always_comb begin
            best_aux_d = best_aux_q;
            if (take) begin
                best_aux_d = s_aux;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                best_aux_q <= '0;
            end else begin
                best_aux_q <= best_aux_d;
            end
        end

        assign m_aux = best_aux_q;
    end else begin : g_no_aux
        logic unused_aux;
        assign unused_aux = ^s_aux;
        assign m_aux      = '0;
    end

endmodule
